// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Optional macro UART_RX_MAJORITY_EN enables 3-sample majority voting.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam logic [31:0] C_FULL = 32'(BAUD_DIV - 1);
  localparam logic [31:0] C_HALF = 32'(HALF_DIV - 1);

  if (BAUD_DIV < 4) begin : g_bad_div
    $error("uart_rx: BAUD_DIV must be >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [31:0] r_baud_cnt;
  logic [31:0] w_baud_nxt;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_ferr;
  logic        w_ferr_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        w_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // current synchronised value plus the two before it
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_rx_s2};
    end
  end

  assign w_bit = (r_rx_s2 & r_hist[0]) |
                 (r_rx_s2 & r_hist[1]) |
                 (r_hist[0] & r_hist[1]);
`else
  assign w_bit = r_rx_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ferr     <= w_ferr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (r_rx_prev && !r_rx_s2) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_baud_nxt = r_baud_cnt + 32'd1;
        // half-bit check: a high line here was only a glitch
        if (r_baud_cnt == C_HALF) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_baud_nxt = r_baud_cnt + 32'd1;
        if (r_baud_cnt == C_FULL) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {w_bit, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_baud_nxt = r_baud_cnt + 32'd1;
        if (r_baud_cnt == C_FULL) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
          if (w_bit) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed 8N1 frames at BAUD_DIV=16 with a
// scoreboard of expected output pulses.
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   pt[$];
  int   n_total;
  int   n_bad;
  int   cyc;
  int   n_busy;

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit err, input logic [7:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    q.push_back(e);
  endtask

  // one clock; outputs observed at the falling edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rx_busy) n_busy++;
    if (rx_valid || rx_frame_err) begin
      pt.push_back(cyc);
      chk("pulse_onehot", 32'(rx_valid & rx_frame_err), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 32'(rx_frame_err), 32'(e.err));
        chk("pulse_data", 32'(rx_data), 32'(e.data));
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_frame(input logic [7:0] d,
                             input logic stop,
                             input int nbits,
                             input bit glitch);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < BD; c++) begin
        if (glitch && b >= 1 && b <= 8 && c == BD / 2)
          rx = ~f[b];
        else
          rx = f[b];
        step();
      end
    end
  endtask

  initial begin
    logic [7:0] maj_exp;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    n_busy  = 0;
    rst_n   = 1'b0;
    rx      = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_ferr", 32'(rx_frame_err), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    idle(20);

    push(1'b0, 8'hA5);
    n_busy = 0;
    drive_frame(8'hA5, 1'b1, 10, 1'b0);
    idle(4);
    chk("single_drain", 32'(q.size()), 0);
    chk("single_busy_len", 32'(n_busy >= 148 && n_busy <= 154), 1);

    pt.delete();
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    push(1'b0, 8'h55);
    push(1'b0, 8'h80);
    drive_frame(8'h00, 1'b1, 10, 1'b0);
    drive_frame(8'hFF, 1'b1, 10, 1'b0);
    drive_frame(8'h55, 1'b1, 10, 1'b0);
    drive_frame(8'h80, 1'b1, 10, 1'b0);
    idle(4);
    chk("b2b_drain", 32'(q.size()), 0);
    chk("b2b_count", 32'(pt.size()), 4);
    for (int i = 1; i < pt.size(); i++) begin
      chk("b2b_gap", 32'(pt[i] - pt[i-1] >= 159 &&
                         pt[i] - pt[i-1] <= 161), 1);
    end

    pt.delete();
    push(1'b1, 8'h80);
    drive_frame(8'h3C, 1'b0, 10, 1'b0);
    rx = 1'b0;
    for (int i = 0; i < 3 * BD; i++) step();
    chk("ferr_drain", 32'(q.size()), 0);
    chk("ferr_count", 32'(pt.size()), 1);
    chk("ferr_hold_data", 32'(rx_data), 32'h80);
    chk("ferr_no_retrig", 32'(rx_busy), 0);
    idle(2 * BD);
    chk("ferr_rise_idle", 32'(rx_busy), 0);

    n_busy = 0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) step();
    idle(40);
    chk("glitch_busy_len", 32'(n_busy >= 1 && n_busy <= 11), 1);
    chk("glitch_no_pulse", 32'(q.size()), 0);

`ifdef UART_RX_MAJORITY_EN
    maj_exp = 8'h5A;
`else
    maj_exp = 8'hA5;
`endif
    push(1'b0, maj_exp);
    drive_frame(8'h5A, 1'b1, 10, 1'b1);
    idle(4);
    chk("maj_drain", 32'(q.size()), 0);
    chk("maj_data", 32'(rx_data), 32'(maj_exp));

    drive_frame(8'hC3, 1'b1, 5, 1'b0);
    rx = 1'b0;
    for (int i = 0; i < BD / 2; i++) step();
    chk("mid_busy", 32'(rx_busy), 1);
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_data", 32'(rx_data), 0);
    chk("mrst_valid", 32'(rx_valid), 0);
    chk("mrst_ferr", 32'(rx_frame_err), 0);
    chk("mrst_busy", 32'(rx_busy), 0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_idle", 32'(rx_busy), 0);
    push(1'b0, 8'h81);
    drive_frame(8'h81, 1'b1, 10, 1'b0);
    idle(4);
    chk("post_rst_drain", 32'(q.size()), 0);
    chk("post_rst_data", 32'(rx_data), 32'h81);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
